// File: rtl/imem_arbiter.sv
// imem_arbiter: two-port (fetch / loader) arbiter in front of a single-port
// 16-bit instruction memory. Alternating priority, loader exclusive lock,
// out-of-range detection and tagged one-cycle-latency read responses.
module imem_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              f_req,
  input  logic [15:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [15:0]       f_rdata,
  // loader port
  input  logic              l_req,
  input  logic              l_we,
  input  logic [15:0]       l_addr,
  input  logic [15:0]       l_wdata,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [15:0]       l_rdata,
  // status
  output logic [1:0]        err,
  // memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata
);

  localparam logic [1:0] PRI_F = 2'd0;  // fetch wins ties
  localparam logic [1:0] PRI_L = 2'd1;  // loader wins ties
  localparam logic [1:0] LOCK  = 2'd2;  // loader owns the memory

  logic [1:0] state, state_nxt;
  logic       f_oor, l_oor;
  logic       rd_issue;
  logic       l_rd_busy;
  // response pipeline: one read in flight, tagged with its owner
  logic       rsp_valid;
  logic       rsp_owner;  // 0 = fetch, 1 = loader
  logic       rsp_oor;

  // Byte-offset bits select within a word and are deliberately ignored.
  logic unused_ok;
  assign unused_ok = ^{f_addr[1:0], l_addr[1:0]};

  // Any byte address above the 2^ADDR_W-word window is out of range.
  assign f_oor = (f_addr >> (ADDR_W + 2)) != 16'd0;
  assign l_oor = (l_addr >> (ADDR_W + 2)) != 16'd0;

  // Grant decode from requests and priority state; held off during reset.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst) begin
      case (state)
        PRI_F: begin
          f_gnt = f_req;
          l_gnt = l_req & ~f_req;
        end
        PRI_L: begin
          l_gnt = l_req;
          f_gnt = f_req & ~l_req;
        end
        LOCK:    l_gnt = l_req;
        default: ;
      endcase
    end
  end

  // Memory command from whichever side holds the grant this cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_gnt) begin
      mem_en    = ~f_oor;
      mem_addr  = f_addr[ADDR_W+1:2];
      mem_wdata = l_wdata;
    end else if (l_gnt) begin
      mem_en    = ~l_oor;
      mem_we    = l_we & ~l_oor;  // never write outside the window
      mem_addr  = l_addr[ADDR_W+1:2];
      mem_wdata = l_wdata;
    end
  end

  assign rd_issue  = f_gnt | (l_gnt & ~l_we);
  // A loader read is outstanding if issued now or answering this cycle.
  assign l_rd_busy = (l_gnt & ~l_we) | (rsp_valid & rsp_owner);

  // Priority rotation and lock entry / exit.
  always_comb begin
    state_nxt = state;
    case (state)
      PRI_F, PRI_L: begin
        if (l_lock)     state_nxt = LOCK;
        else if (f_gnt) state_nxt = PRI_L;
        else if (l_gnt) state_nxt = PRI_F;
      end
      LOCK: begin
        if (!l_lock && !l_rd_busy) state_nxt = PRI_F;
      end
      default: state_nxt = PRI_F;
    endcase
  end

  // State, response tag and error flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= PRI_F;
      rsp_valid <= 1'b0;
      rsp_owner <= 1'b0;
      rsp_oor   <= 1'b0;
      err       <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state     <= state_nxt;
      rsp_valid <= rd_issue;
      rsp_owner <= l_gnt;
      rsp_oor   <= f_gnt ? f_oor : l_oor;
      err       <= {l_gnt & l_oor, f_gnt & f_oor};
    end
  end

  // Route the response by owner tag; data is zero unless valid and in range.
  assign f_rvalid = rsp_valid & ~rsp_owner;
  assign l_rvalid = rsp_valid &  rsp_owner;
  assign f_rdata  = (f_rvalid && !rsp_oor) ? mem_rdata : 16'h0000;
  assign l_rdata  = (l_rvalid && !rsp_oor) ? mem_rdata : 16'h0000;

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 10, word-index width of the shared instruction memory (2^ADDR_W 16-bit words).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 f_req  input  1  fetch-side read request, held until granted.
REQ-005 f_addr  input  16  fetch byte address.
REQ-006 f_gnt  output  1  fetch request accepted this cycle.
REQ-007 f_rvalid  output  1  fetch read data valid.
REQ-008 f_rdata  output  16  fetch read data.
REQ-009 l_req  input  1  loader request, held until granted.
REQ-010 l_we  input  1  loader write (1) or read (0).
REQ-011 l_addr  input  16  loader byte address.
REQ-012 l_wdata  input  16  loader write data.
REQ-013 l_lock  input  1  loader exclusive-access request.
REQ-014 l_gnt, l_rvalid  output  1 each  loader accept / read-data-valid.
REQ-015 l_rdata  output  16  loader read data.
REQ-016 err  output  2  one-cycle out-of-range flag; bit0 = fetch, bit1 = loader.
REQ-017 mem_en, mem_we  output  1 each  memory access enable / write enable.
REQ-018 mem_addr  output  ADDR_W  memory word index.
REQ-019 mem_wdata  output  16  memory write data.
REQ-020 mem_rdata  input  16  memory read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-021 FSM states SHALL be PRI_F (fetch wins ties), PRI_L (loader wins ties) and LOCK.
REQ-022 At most one grant per cycle; f_gnt and l_gnt combinational from req inputs and state, never both 1.
REQ-023 PRI_F: f_req wins, else l_req wins; PRI_L: l_req wins, else f_req wins.
REQ-024 After a fetch grant, next state PRI_L; after a loader grant, next state PRI_F; with no grant, state holds.
REQ-025 l_lock=1 in PRI_F/PRI_L -> next state LOCK; in LOCK, f_gnt=0 and l_req is granted every cycle it is asserted.
REQ-026 LOCK exits to PRI_F on the first cycle l_lock=0 with no loader read awaiting rvalid; otherwise LOCK holds one more cycle.
REQ-027 On grant: mem_en=1, mem_addr = granted addr[ADDR_W+1:2], addr[1:0] ignored; mem_we = l_we for loader and 0 for fetch; mem_wdata = l_wdata.
REQ-028 Out of range (addr[15:ADDR_W+2] nonzero): grant still given, mem_en=0; next cycle the matching err bit = 1.
REQ-029 Out-of-range read: rvalid = 1 with rdata = 0.
REQ-030 In-range read: owner's rvalid=1 exactly one cycle after grant, rdata = mem_rdata; the other requester's rvalid=0.
REQ-031 Writes SHALL produce no rvalid.
REQ-032 rdata SHALL be 0 whenever rvalid=0.
REQ-033 Back-to-back grants SHALL be allowed; an owner tag register routes each response independently of the current cycle's grant.
REQ-034 mem_en=0 and mem_we=0 in any cycle with no grant.

Reset
REQ-035 While rst=0: state = PRI_F; f_gnt, l_gnt, f_rvalid, l_rvalid, err, mem_en, mem_we = 0; rdata outputs, mem_addr, mem_wdata = 0.
REQ-036 Reset asserted mid-operation SHALL discard any pending read response: no rvalid after rst returns to 1.
REQ-037 After reset release, the first simultaneous request SHALL go to fetch.

Verification
REQ-038 Reset, then f_req=1 and l_req=1 held for 4 cycles -> grants alternate F, L, F, L; each read returns rvalid to the correct side one cycle later.
REQ-039 l_lock=1 with a loader write burst to addresses 0x0000, 0x0004, 0x0008 while f_req=1 -> f_gnt=0 throughout; mem_addr=0,1,2, mem_we=1, no rvalid; fetch is granted in the first cycle after l_lock=0.
REQ-040 Loader writes 0x0904 at 0x0000, then fetch reads 0x0000 -> f_rvalid=1, f_rdata=0x0904, l_rvalid=0.
REQ-041 f_addr=0x1000 with ADDR_W=10 -> f_gnt=1, mem_en=0; next cycle err=2'b01, f_rvalid=1, f_rdata=0.
REQ-042 rst pulsed low in the cycle after a fetch read grant -> f_rvalid never asserts; state is PRI_F after release.
REQ-043 f_addr=0x0007 -> mem_addr=1.
